// File: rtl/fod_spi_pkg.sv
// Shared constants for the FOD SPI register bank: addresses, field widths,
// reset values and per-register writable-bit masks.
package fod_spi_pkg;

    localparam int WI        = 7;
    localparam int WF        = 16;
    localparam int FRAME_LEN = 24;
    localparam int CNT_W     = 5;
    localparam int NUM_REGS  = 11;

    localparam logic [6:0] ADDR_FCW_FRAC = 7'h00;
    localparam logic [6:0] ADDR_FCW_INT  = 7'h01;
    localparam logic [6:0] ADDR_EN       = 7'h02;
    localparam logic [6:0] ADDR_CAL_KS   = 7'h03;
    localparam logic [6:0] ADDR_PHASE    = 7'h04;
    localparam logic [6:0] ADDR_PSEG     = 7'h05;
    localparam logic [6:0] ADDR_KBCD     = 7'h06;
    localparam logic [6:0] ADDR_KDTCB    = 7'h07;
    localparam logic [6:0] ADDR_KDTCC    = 7'h08;
    localparam logic [6:0] ADDR_KDTCD0   = 7'h09;
    localparam logic [6:0] ADDR_KDTCD1   = 7'h0A;
    localparam logic [6:0] ADDR_LAST     = ADDR_KDTCD1;
    localparam logic [6:0] ADDR_ID       = 7'h7F;

    localparam logic [WI+WF-1:0] RST_FCW     = 23'h08428F;
    localparam logic [15:0]      RST_EN      = 16'h0312;
    localparam logic [15:0]      RST_CAL_KS  = 16'h4100;
    localparam logic [15:0]      RST_PSEG    = 16'h000F;
    localparam logic [15:0]      RST_KBCD    = 16'h77A0;
    localparam logic [15:0]      RST_KDTCB   = 16'd694;
    localparam logic [15:0]      RST_KDTCC   = 16'd347;
    localparam logic [15:0]      RST_KDTCD   = 16'd100;

    function automatic logic [15:0] reg_rst(input logic [6:0] addr);
        case (addr)
            ADDR_FCW_FRAC: reg_rst = RST_FCW[WF-1:0];
            ADDR_FCW_INT:  reg_rst = {9'd0, RST_FCW[WI+WF-1:WF]};
            ADDR_EN:       reg_rst = RST_EN;
            ADDR_CAL_KS:   reg_rst = RST_CAL_KS;
            ADDR_PSEG:     reg_rst = RST_PSEG;
            ADDR_KBCD:     reg_rst = RST_KBCD;
            ADDR_KDTCB:    reg_rst = RST_KDTCB;
            ADDR_KDTCC:    reg_rst = RST_KDTCC;
            ADDR_KDTCD0,
            ADDR_KDTCD1:   reg_rst = RST_KDTCD;
            default:       reg_rst = 16'h0000;
        endcase
    endfunction

    // Bits outside the mask are never stored, so they always read back as 0.
    function automatic logic [15:0] reg_mask(input logic [6:0] addr);
        case (addr)
            ADDR_FCW_FRAC: reg_mask = 16'hFFFF;
            ADDR_FCW_INT:  reg_mask = 16'h007F;
            ADDR_EN:       reg_mask = 16'h07FF;
            ADDR_CAL_KS:   reg_mask = 16'h7FFF;
            ADDR_PHASE:    reg_mask = 16'h03FF;
            ADDR_PSEG:     reg_mask = 16'h000F;
            ADDR_KBCD:     reg_mask = 16'h7FFF;
            ADDR_KDTCB,
            ADDR_KDTCC,
            ADDR_KDTCD0,
            ADDR_KDTCD1:   reg_mask = 16'h03FF;
            default:       reg_mask = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/fod_spi_shifter.sv
// SPI mode-0 slave front end: oversampled pin synchronisers, edge detect,
// bit counter, frame capture and read-data shift-out.
module fod_spi_shifter
    import fod_spi_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              frame_done,
    output logic              frame_err,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data
);

    localparam logic [CNT_W-1:0] HDR_BITS  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_LEN + 1);

    logic [2:0]           sck_sr;
    logic [2:0]           csn_sr;
    logic [1:0]           mosi_sr;
    logic                 in_frame;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [FRAME_LEN-1:0] sin;
    logic [FRAME_LEN-1:0] sin_nxt;
    logic [FRAME_LEN-1:0] word_q;
    logic [DATA_W-2:0]    sout;

    // Sync flops reset low so a CSN held low through reset never looks like a fall.
    wire sck_rise = sck_sr[1] & ~sck_sr[2];
    wire sck_fall = ~sck_sr[1] & sck_sr[2];
    wire csn_rise = csn_sr[1] & ~csn_sr[2];
    wire csn_fall = ~csn_sr[1] & csn_sr[2];

    // Next-state view lets an SCK rise coincident with the CSN rise count first.
    always_comb begin
        cnt_nxt = bit_cnt;
        sin_nxt = sin;
        if (in_frame && sck_rise) begin
            sin_nxt = {sin[FRAME_LEN-2:0], mosi_sr[1]};
            if (bit_cnt != CNT_SAT) begin
                cnt_nxt = bit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sr      <= '0;
            csn_sr      <= '0;
            mosi_sr     <= '0;
            in_frame    <= 1'b0;
            bit_cnt     <= '0;
            sin         <= '0;
            word_q      <= '0;
            sout        <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sck_sr     <= {sck_sr[1:0], spi_sck};
            csn_sr     <= {csn_sr[1:0], spi_csn};
            mosi_sr    <= {mosi_sr[0], spi_mosi};
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (csn_fall) begin
                in_frame <= 1'b1;
                bit_cnt  <= '0;
                sin      <= '0;
            end else if (in_frame) begin
                bit_cnt <= cnt_nxt;
                sin     <= sin_nxt;
                if (csn_rise) begin
                    in_frame <= 1'b0;
                    if (cnt_nxt == FRAME_CNT) begin
                        frame_done <= 1'b1;
                        word_q     <= sin_nxt;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end

            spi_miso_oe <= csn_fall | (in_frame & ~csn_rise);

            if (csn_fall || csn_rise || !in_frame) begin
                spi_miso <= 1'b0;
                sout     <= '0;
            end else if (sck_fall) begin
                if (bit_cnt == HDR_BITS) begin
                    spi_miso <= sin[ADDR_W] & rd_data[DATA_W-1];
                    sout     <= sin[ADDR_W] ? rd_data[DATA_W-2:0] : '0;
                end else if (bit_cnt > HDR_BITS && bit_cnt < FRAME_CNT) begin
                    spi_miso <= sout[DATA_W-2];
                    sout     <= {sout[DATA_W-3:0], 1'b0};
                end else begin
                    spi_miso <= 1'b0;
                end
            end
        end
    end

    assign rd_addr    = sin[ADDR_W-1:0];
    assign frame_rw   = word_q[FRAME_LEN-1];
    assign frame_addr = word_q[DATA_W+ADDR_W-1:DATA_W];
    assign frame_data = word_q[DATA_W-1:0];

endmodule

// File: rtl/fod_spi_regbank.sv
// SPI register bank producing the static control words of the FOD controller,
// including the shadowed, atomically updated FCW.
module fod_spi_regbank
    import fod_spi_pkg::*;
#(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hF0D1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SPI_SCK,
    input  logic               SPI_CSN,
    input  logic               SPI_MOSI,
    output logic               SPI_MISO,
    output logic               SPI_MISO_OE,
    output logic               WR_STROBE,
    output logic               FRAME_ERR,
    output logic [WI+WF-1:0]   FCW_FOD,
    output logic               SYS_EN,
    output logic               PCALI_EN,
    output logic               FREQ_C_EN,
    output logic               FREQ_C_MODE,
    output logic               RT_EN,
    output logic               DTCCALI_EN,
    output logic               OFSTCALI_EN,
    output logic               FCW_DN_EN,
    output logic               DSM_SYNC_NRST_EN,
    output logic               NCO_SYNC_NRST_EN,
    output logic               FREQ_HOP,
    output logic [4:0]         FREQ_C_KS,
    output logic [4:0]         PCALI_KS,
    output logic [2:0]         PCALI_FREQDOWN,
    output logic [1:0]         FCW_DN_WEIGHT,
    output logic [9:0]         PHASE_CTRL,
    output logic [1:0]         PSEG,
    output logic [1:0]         CALIORDER,
    output logic [4:0]         KB,
    output logic [4:0]         KC,
    output logic [4:0]         KD,
    output logic [9:0]         KDTCB_INIT,
    output logic [9:0]         KDTCC_INIT,
    output logic [9:0]         KDTCD_INIT0,
    output logic [9:0]         KDTCD_INIT1
);

    logic [DATA_W-1:0] reg_q [NUM_REGS];
    logic [WF-1:0]     fcw_frac_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              frame_done;
    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;

    fod_spi_shifter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk         (CLK),
        .rst         (RST),
        .spi_sck     (SPI_SCK),
        .spi_csn     (SPI_CSN),
        .spi_mosi    (SPI_MOSI),
        .rd_data     (rd_data),
        .rd_addr     (rd_addr),
        .spi_miso    (SPI_MISO),
        .spi_miso_oe (SPI_MISO_OE),
        .frame_done  (frame_done),
        .frame_err   (FRAME_ERR),
        .frame_rw    (frame_rw),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data)
    );

    wire       wr_hit = frame_done & ~frame_rw & (frame_addr <= ADDR_LAST);
    wire [3:0] wr_idx = frame_addr[3:0];

    // Address 0x00 is only a shadow; the live fraction moves when 0x01 is written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= reg_rst(7'(i));
            end
            fcw_frac_q <= RST_FCW[WF-1:0];
            WR_STROBE  <= 1'b0;
        end else begin
            WR_STROBE <= wr_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit && wr_idx == 4'(i)) begin
                    reg_q[i] <= frame_data & reg_mask(7'(i));
                end
            end
            if (wr_hit && frame_addr == ADDR_FCW_INT) begin
                fcw_frac_q <= reg_q[0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr <= ADDR_LAST) begin
            rd_data = reg_q[rd_addr[3:0]];
        end else if (rd_addr == ADDR_ID) begin
            rd_data = ID_VALUE;
        end
    end

    assign FCW_FOD          = {reg_q[1][WI-1:0], fcw_frac_q};
    assign SYS_EN           = reg_q[2][0];
    assign PCALI_EN         = reg_q[2][1];
    assign FREQ_C_EN        = reg_q[2][2];
    assign FREQ_C_MODE      = reg_q[2][3];
    assign RT_EN            = reg_q[2][4];
    assign DTCCALI_EN       = reg_q[2][5];
    assign OFSTCALI_EN      = reg_q[2][6];
    assign FCW_DN_EN        = reg_q[2][7];
    assign DSM_SYNC_NRST_EN = reg_q[2][8];
    assign NCO_SYNC_NRST_EN = reg_q[2][9];
    assign FREQ_HOP         = reg_q[2][10];
    assign FREQ_C_KS        = reg_q[3][4:0];
    assign PCALI_KS         = reg_q[3][9:5];
    assign PCALI_FREQDOWN   = reg_q[3][12:10];
    assign FCW_DN_WEIGHT    = reg_q[3][14:13];
    assign PHASE_CTRL       = reg_q[4][9:0];
    assign PSEG             = reg_q[5][1:0];
    assign CALIORDER        = reg_q[5][3:2];
    assign KB               = reg_q[6][4:0];
    assign KC               = reg_q[6][9:5];
    assign KD               = reg_q[6][14:10];
    assign KDTCB_INIT       = reg_q[7][9:0];
    assign KDTCC_INIT       = reg_q[8][9:0];
    assign KDTCD_INIT0      = reg_q[9][9:0];
    assign KDTCD_INIT1      = reg_q[10][9:0];

endmodule
